// File: rtl/riscv_pkg.sv
// Shared core types: datapath width and the result payload that every
// execution stage hands to writeback.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } wb_payload_t;

endpackage

// File: rtl/axis_if.sv
// Valid/ready stream carrying one writeback payload per transfer.
interface axis_if;
  import riscv_pkg::*;

  logic        tvalid;
  logic        tready;
  wb_payload_t tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the entry after
// the last winner; the pointer moves only when advance is asserted.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx, gnt_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr_q;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % N);
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  assign ptr_d = advance ? gnt_idx : ptr_q;

  // Reset to the last index so source 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PtrW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates ALU/CSR/LSU results round-robin and drives a
// registered register-file write port plus the retire counter.
module writeback #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned XLEN    = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  axis_if.slave           src_axis_if [NUM_SRC],
  input  logic            invalidate,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire,
  output logic [63:0]     instret
);
  import riscv_pkg::*;

  logic [NUM_SRC-1:0] valid;
  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] ready;
  wb_payload_t        data [NUM_SRC];
  wb_payload_t        sel;
  logic               xfer;

  logic            rf_we_q, retire_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [63:0]     instret_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign valid[g]                = src_axis_if[g].tvalid;
    assign data[g]                 = src_axis_if[g].tdata;
    assign src_axis_if[g].tready   = ready[g];
  end

  rr_arbiter #(
    .N(NUM_SRC)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (valid),
    .advance(xfer),
    .gnt    (gnt)
  );

  // Ready depends only on valid, the pointer, flush and reset, never on tdata.
  assign ready = (rst && !invalidate) ? gnt : '0;
  assign xfer  = |ready;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (ready[i]) sel = data[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      retire_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      instret_q  <= '0;
    end else begin
      retire_q <= xfer;
      rf_we_q  <= xfer && (sel.rd != 5'd0);
      if (xfer && (sel.rd != 5'd0)) begin
        rf_waddr_q <= sel.rd;
        rf_wdata_q <= sel.result;
      end
      if (xfer) instret_q <= instret_q + 64'd1;
    end
  end

  assign rf_we    = rf_we_q;
  assign retire   = retire_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Randomized bench for writeback against a cycle-level arbitration model.
module tb_writeback;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic        invalidate;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic [63:0] instret;

  logic [N-1:0] tb_valid;
  logic [N-1:0] tb_ready;
  logic [4:0]   tb_rd  [N];
  logic [31:0]  tb_res [N];

  axis_if src_if [N] ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign src_if[g].tvalid        = tb_valid[g];
    assign src_if[g].tdata.rd      = tb_rd[g];
    assign src_if[g].tdata.result  = tb_res[g];
    assign tb_ready[g]             = src_if[g].tready;
  end

  writeback #(
    .NUM_SRC(N),
    .XLEN   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_axis_if(src_if),
    .invalidate (invalidate),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .retire     (retire),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: last winner, retire count, expected write port.
  int          m_last;
  logic [63:0] m_instret;
  logic        exp_we, exp_ret;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("rf_we",    64'(rf_we),    64'(exp_we));
    check("retire",   64'(retire),   64'(exp_ret));
    check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
    check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
    check("instret",  instret,       m_instret);
  endtask

  task automatic model_reset();
    m_last    = N - 1;
    m_instret = '0;
    exp_we    = 1'b0;
    exp_ret   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic inv);
    int grant;
    int idx;
    check_outputs();
    tb_valid   = v;
    invalidate = inv;
    #1;
    grant = -1;
    if (!inv) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (grant < 0 && v[idx]) grant = idx;
      end
    end
    last_ready = tb_ready;
    check("tready", 64'(tb_ready), (grant >= 0) ? (64'd1 << grant) : 64'd0);
    if (grant >= 0) begin
      m_last    = grant;
      m_instret = m_instret + 64'd1;
      exp_ret   = 1'b1;
      exp_we    = (tb_rd[grant] != 5'd0);
      if (tb_rd[grant] != 5'd0) begin
        exp_waddr = tb_rd[grant];
        exp_wdata = tb_res[grant];
      end
    end else begin
      exp_ret = 1'b0;
      exp_we  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    tb_valid   = '1;
    invalidate = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs();
    check("rst_tready", 64'(tb_ready), 64'd0);
    tb_valid = '0;
    rst      = 1'b1;
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b0;
    invalidate = 1'b0;
    tb_valid   = '0;
    for (int i = 0; i < N; i++) begin
      tb_rd[i]  = '0;
      tb_res[i] = '0;
    end
    model_reset();

    // Single ALU write.
    do_reset();
    tb_rd[0]  = 5'd5;
    tb_res[0] = 32'hDEADBEEF;
    step(3'b001, 1'b0);
    check("alu_we",      64'(rf_we),    64'd1);
    check("alu_waddr",   64'(rf_waddr), 64'd5);
    check("alu_wdata",   64'(rf_wdata), 64'hDEADBEEF);
    check("alu_retire",  64'(retire),   64'd1);
    check("alu_instret", instret,       64'd1);
    step(3'b000, 1'b0);

    // All sources valid: strict rotation from source 0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      tb_rd[i]  = 5'(i + 1);
      tb_res[i] = $urandom;
    end
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 1'b0);
      check("rr_seq", 64'(last_ready), 64'd1 << (k % 3));
    end
    step(3'b000, 1'b0);
    check("rr_instret", instret, 64'd6);

    // rd=0 retires without writing.
    tb_rd[1]  = 5'd0;
    tb_res[1] = 32'h1234;
    step(3'b010, 1'b0);
    check("x0_we",      64'(rf_we),  64'd0);
    check("x0_retire",  64'(retire), 64'd1);
    check("x0_instret", instret,     64'd7);

    // Flush blocks the cycle and leaves the pointer alone.
    step(3'b101, 1'b1);
    check("inv_we",     64'(rf_we),  64'd0);
    check("inv_retire", 64'(retire), 64'd0);
    step(3'b101, 1'b0);
    check("inv_ptr", 64'(last_ready), 64'b100);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        tb_rd[i]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        tb_res[i] = $urandom;
      end
      step(N'($urandom), ($urandom_range(0, 9) == 0));
    end
    step(3'b000, 1'b0);

    // Counter wrap from all ones.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    check("instret_wrap", instret, 64'd0);

    // Asynchronous reset in the middle of a stream.
    step(3'b111, 1'b0);
    step(3'b111, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_we",      64'(rf_we),    64'd0);
    check("arst_retire",  64'(retire),   64'd0);
    check("arst_waddr",   64'(rf_waddr), 64'd0);
    check("arst_wdata",   64'(rf_wdata), 64'd0);
    check("arst_instret", instret,       64'd0);
    check("arst_tready",  64'(tb_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(3'b111, 1'b0);
    check("arst_first", 64'(last_ready), 64'b001);
    step(3'b000, 1'b0);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
